// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-stage register/enable information in,
// stall/flush/forwarding controls out. The controller takes the slave side.
interface hazard_ctrl_if;
  logic [4:0]  rsD, rtD, rsE, rtE;
  logic [4:0]  writeregE, writeregM, writeregW;
  logic        regwriteE, regwriteM, regwriteW;
  logic        memtoregE, memtoregM;
  logic        branchD, jrD;
  logic        divE;
  logic        mem_enM, mem_ackM;
  logic [31:0] excepttypeM;

  logic        stallF, stallD, stallE, stallM, stallW;
  logic        flushD, flushE, flushM, flushW;
  logic        pc_redirectF;
  logic        forwardAD, forwardBD;
  logic [1:0]  forwardAE, forwardBE;
  logic        div_startE, div_doneE;
  logic        mem_errM;

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, jrD, divE, mem_enM, mem_ackM, excepttypeM,
    output stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW, pc_redirectF,
           forwardAD, forwardBD, forwardAE, forwardBE,
           div_startE, div_doneE, mem_errM
  );

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, jrD, divE, mem_enM, mem_ackM, excepttypeM,
    input  stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW, pc_redirectF,
           forwardAD, forwardBD, forwardAE, forwardBE,
           div_startE, div_doneE, mem_errM
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer and forwarding selects for the
// five-stage core. Handles load-use/branch hazards, the iterative divide,
// data-memory wait states and precise exception flushes.
// Optional build macro HAZARD_MEM_TIMEOUT_EN adds a wait-state timeout that
// raises mem_errM and applies the exception flush.
//
// state    | meaning
// RUN      | normal flow; hazards resolved combinationally
// DIV_WAIT | divider busy, F/D/E frozen, bubbles into M
// MEM_WAIT | data bus stalled, F/D/E/M frozen, bubbles into W
module hazard_ctrl #(
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, DIV_WAIT, MEM_WAIT} state_t;

  localparam int            CW       = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          div_done_q, div_done_d;
  logic          tmo_hit;
  logic          exc;
  logic          lwstall, branchstall;

  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic redirect_f, div_start, div_done;
  logic fwd_ad, fwd_bd;
  logic [1:0] fwd_ae, fwd_be;

`ifdef HAZARD_MEM_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  // Wait-state down-counter; terminal count 1 marks the MEM_TIMEOUT-th wait cycle.
  assign tmo_hit = (state_q == MEM_WAIT) && !hz.mem_ackM && (tmo_q == 8'd1);

  // Timeout counter next value: load on entry, count down while waiting.
  always_comb begin
    tmo_d = tmo_q;
    if (exc)
      tmo_d = 8'd0;
    else if (state_q == RUN && state_d == MEM_WAIT)
      tmo_d = 8'(MEM_TIMEOUT - 1);
    else if (state_q == MEM_WAIT && !hz.mem_ackM)
      tmo_d = tmo_q - 8'd1;
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= 8'd0;
    else     tmo_q <= tmo_d;
  end
`else
  logic [7:0] unused_tmo;
  assign unused_tmo = 8'(MEM_TIMEOUT);
  assign tmo_hit    = 1'b0;
`endif

  assign exc = (|hz.excepttypeM) | tmo_hit;

  assign lwstall = hz.memtoregE && (hz.rtE == hz.rsD || hz.rtE == hz.rtD);
  assign branchstall = (hz.branchD || hz.jrD) &&
      ((hz.regwriteE && (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD)) ||
       (hz.memtoregM && (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD)));

  // State, divide counter and divide-complete flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      div_cnt_q  <= '0;
      div_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_done_q <= div_done_d;
    end
  end

  // Next state, stall/flush sequencing and forwarding selects.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    div_done_d = div_done_q;
    stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
    flush_d = 1'b0; flush_e = 1'b0; flush_m = 1'b0; flush_w = 1'b0;
    redirect_f = 1'b0; div_start = 1'b0; div_done = 1'b0;

    fwd_ad = hz.regwriteM && (hz.writeregM != 5'd0) && (hz.writeregM == hz.rsD);
    fwd_bd = hz.regwriteM && (hz.writeregM != 5'd0) && (hz.writeregM == hz.rtD);
    if (hz.regwriteM && hz.writeregM != 5'd0 && hz.writeregM == hz.rsE)      fwd_ae = 2'b10;
    else if (hz.regwriteW && hz.writeregW != 5'd0 && hz.writeregW == hz.rsE) fwd_ae = 2'b01;
    else                                                                     fwd_ae = 2'b00;
    if (hz.regwriteM && hz.writeregM != 5'd0 && hz.writeregM == hz.rtE)      fwd_be = 2'b10;
    else if (hz.regwriteW && hz.writeregW != 5'd0 && hz.writeregW == hz.rtE) fwd_be = 2'b01;
    else                                                                     fwd_be = 2'b00;

    if (exc) begin
      flush_d = 1'b1; flush_e = 1'b1; flush_m = 1'b1; flush_w = 1'b1;
      redirect_f = 1'b1;
      state_d    = RUN;
      div_cnt_d  = '0;
      div_done_d = 1'b0;
    end else begin
      unique case (state_q)
        MEM_WAIT: begin
          if (hz.mem_ackM) begin
            state_d = RUN;
          end else begin
            stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
            flush_w = 1'b1;
          end
        end
        DIV_WAIT: begin
          if (div_cnt_q == '0) begin
            div_done   = 1'b1;
            div_done_d = 1'b1;
            state_d    = RUN;
          end else begin
            stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1;
            flush_m   = 1'b1;
            div_cnt_d = div_cnt_q - 1'b1;
          end
        end
        default: begin
          if (hz.mem_enM && !hz.mem_ackM) begin
            stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
            flush_w = 1'b1;
            state_d = MEM_WAIT;
          end else if (hz.divE && !div_done_q) begin
            div_start = 1'b1;
            stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1;
            flush_m   = 1'b1;
            div_cnt_d = DIV_LOAD;
            state_d   = DIV_WAIT;
          end else if (lwstall || branchstall) begin
            stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
          end
        end
      endcase
      // The done flag only blocks a restart until E has actually advanced.
      if (!div_done && !stall_e) div_done_d = 1'b0;
    end

    if (rst) begin
      stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
      flush_d = 1'b0; flush_e = 1'b0; flush_m = 1'b0; flush_w = 1'b0;
      redirect_f = 1'b0; div_start = 1'b0; div_done = 1'b0;
      fwd_ad = 1'b0; fwd_bd = 1'b0; fwd_ae = 2'b00; fwd_be = 2'b00;
    end
  end

  assign hz.stallF       = stall_f;
  assign hz.stallD       = stall_d;
  assign hz.stallE       = stall_e;
  assign hz.stallM       = stall_m;
  assign hz.stallW       = 1'b0;
  assign hz.flushD       = flush_d;
  assign hz.flushE       = flush_e;
  assign hz.flushM       = flush_m;
  assign hz.flushW       = flush_w;
  assign hz.pc_redirectF = redirect_f;
  assign hz.forwardAD    = fwd_ad;
  assign hz.forwardBD    = fwd_bd;
  assign hz.forwardAE    = fwd_ae;
  assign hz.forwardBE    = fwd_be;
  assign hz.div_startE   = div_start;
  assign hz.div_doneE    = div_done;
  assign hz.mem_errM     = tmo_hit & ~rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use/branch stalls,
// divide sequencing, memory wait states, exception abort and (when built
// with HAZARD_MEM_TIMEOUT_EN) the wait-state timeout.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  hazard_ctrl_if hz_if();

  hazard_ctrl #(.DIV_CYCLES(32), .MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_in();
    hz_if.rsD = 5'd0; hz_if.rtD = 5'd0; hz_if.rsE = 5'd0; hz_if.rtE = 5'd0;
    hz_if.writeregE = 5'd0; hz_if.writeregM = 5'd0; hz_if.writeregW = 5'd0;
    hz_if.regwriteE = 1'b0; hz_if.regwriteM = 1'b0; hz_if.regwriteW = 1'b0;
    hz_if.memtoregE = 1'b0; hz_if.memtoregM = 1'b0;
    hz_if.branchD = 1'b0; hz_if.jrD = 1'b0; hz_if.divE = 1'b0;
    hz_if.mem_enM = 1'b0; hz_if.mem_ackM = 1'b0; hz_if.excepttypeM = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st_cnt, dn_cnt;
    clear_in();
    rst = 1'b1;
    tick();
    // Hazard-looking inputs during reset must not leak through.
    hz_if.regwriteM = 1'b1; hz_if.writeregM = 5'd3; hz_if.rsE = 5'd3; hz_if.rsD = 5'd3;
    hz_if.memtoregE = 1'b1; hz_if.rtE = 5'd3;
    mid();
    check_val("rst_fwdAE", 32'(hz_if.forwardAE), 32'd0);
    check_val("rst_fwdAD", 32'(hz_if.forwardAD), 32'd0);
    check_val("rst_stallF", 32'(hz_if.stallF), 32'd0);
    tick();
    rst = 1'b0;
    clear_in();

    // Forwarding priority: M over W, r0 never forwards.
    hz_if.regwriteM = 1'b1; hz_if.writeregM = 5'd3;
    hz_if.regwriteW = 1'b1; hz_if.writeregW = 5'd3;
    hz_if.rsE = 5'd3; hz_if.rtE = 5'd3; hz_if.rsD = 5'd3;
    mid();
    check_val("fwdAE_M", 32'(hz_if.forwardAE), 32'd2);
    check_val("fwdBE_M", 32'(hz_if.forwardBE), 32'd2);
    check_val("fwdAD_M", 32'(hz_if.forwardAD), 32'd1);
    tick();
    hz_if.writeregM = 5'd0;
    mid();
    check_val("fwdAE_W", 32'(hz_if.forwardAE), 32'd1);
    check_val("fwdAD_r0", 32'(hz_if.forwardAD), 32'd0);
    tick();
    hz_if.regwriteW = 1'b0;
    mid();
    check_val("fwdAE_none", 32'(hz_if.forwardAE), 32'd0);
    tick();
    clear_in();

    // Load-use: lw r5 in E, consumer reads r5 in D.
    hz_if.memtoregE = 1'b1; hz_if.regwriteE = 1'b1; hz_if.writeregE = 5'd5;
    hz_if.rtE = 5'd5; hz_if.rsD = 5'd5;
    mid();
    check_val("lw_stallF", 32'(hz_if.stallF), 32'd1);
    check_val("lw_stallD", 32'(hz_if.stallD), 32'd1);
    check_val("lw_flushE", 32'(hz_if.flushE), 32'd1);
    check_val("lw_stallE", 32'(hz_if.stallE), 32'd0);
    tick();
    clear_in();
    hz_if.memtoregM = 1'b1; hz_if.regwriteM = 1'b1; hz_if.writeregM = 5'd5; hz_if.rsD = 5'd5;
    mid();
    check_val("lw_bubble_stallF", 32'(hz_if.stallF), 32'd0);
    tick();
    clear_in();
    hz_if.regwriteW = 1'b1; hz_if.writeregW = 5'd5; hz_if.rsE = 5'd5;
    mid();
    check_val("lw_fwdAE", 32'(hz_if.forwardAE), 32'd1);
    tick();
    clear_in();

    // Branch stalls on an ALU producer in E and on a load in M.
    hz_if.branchD = 1'b1; hz_if.regwriteE = 1'b1; hz_if.writeregE = 5'd7; hz_if.rsD = 5'd7;
    mid();
    check_val("br_stallF", 32'(hz_if.stallF), 32'd1);
    check_val("br_flushE", 32'(hz_if.flushE), 32'd1);
    tick();
    clear_in();
    hz_if.jrD = 1'b1; hz_if.memtoregM = 1'b1; hz_if.writeregM = 5'd9; hz_if.rtD = 5'd9;
    mid();
    check_val("jr_ldM_stallD", 32'(hz_if.stallD), 32'd1);
    tick();
    clear_in();
    hz_if.branchD = 1'b1; hz_if.rsD = 5'd4; hz_if.regwriteE = 1'b1; hz_if.writeregE = 5'd6;
    mid();
    check_val("br_nohaz_stallF", 32'(hz_if.stallF), 32'd0);
    tick();
    clear_in();

    // Divide: start cycle plus 31 wait cycles frozen, done in the 33rd cycle.
    hz_if.divE = 1'b1;
    mid();
    check_val("div_start", 32'(hz_if.div_startE), 32'd1);
    check_val("div_start_stallE", 32'(hz_if.stallE), 32'd1);
    check_val("div_start_flushM", 32'(hz_if.flushM), 32'd1);
    tick();
    st_cnt = 0; dn_cnt = 0;
    for (int k = 1; k < 32; k++) begin
      mid();
      if (hz_if.stallE && hz_if.stallD && hz_if.stallF && hz_if.flushM) st_cnt++;
      if (hz_if.div_doneE || hz_if.div_startE) dn_cnt++;
      tick();
    end
    check_val("div_wait_stalls", 32'(st_cnt), 32'd31);
    check_val("div_wait_nopulse", 32'(dn_cnt), 32'd0);
    mid();
    check_val("div_done", 32'(hz_if.div_doneE), 32'd1);
    check_val("div_done_stallE", 32'(hz_if.stallE), 32'd0);
    tick();
    mid();
    check_val("div_no_restart", 32'(hz_if.div_startE), 32'd0);
    check_val("div_after_stallE", 32'(hz_if.stallE), 32'd0);
    tick();
    clear_in();

    // Memory wait: three cycles without ack, then ack releases in that cycle.
    hz_if.mem_enM = 1'b1;
    st_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      mid();
      if (hz_if.stallM && hz_if.stallE && hz_if.stallF && hz_if.flushW) st_cnt++;
      tick();
    end
    check_val("mem_wait_stalls", 32'(st_cnt), 32'd3);
    hz_if.mem_ackM = 1'b1;
    mid();
    check_val("mem_ack_stallM", 32'(hz_if.stallM), 32'd0);
    check_val("mem_ack_stallF", 32'(hz_if.stallF), 32'd0);
    tick();
    mid();
    check_val("mem_fast_ack_stallM", 32'(hz_if.stallM), 32'd0);
    tick();
    clear_in();

    // Divide waits behind a memory stall, then starts; exception at count 7 aborts it.
    hz_if.mem_enM = 1'b1; hz_if.divE = 1'b1;
    mid();
    check_val("memdiv_nostart", 32'(hz_if.div_startE), 32'd0);
    check_val("memdiv_stallM", 32'(hz_if.stallM), 32'd1);
    tick();
    hz_if.mem_ackM = 1'b1;
    mid();
    check_val("memdiv_ack_nostart", 32'(hz_if.div_startE), 32'd0);
    tick();
    hz_if.mem_enM = 1'b0; hz_if.mem_ackM = 1'b0;
    mid();
    check_val("memdiv_start", 32'(hz_if.div_startE), 32'd1);
    tick();
    for (int k = 1; k < 25; k++) tick();
    hz_if.excepttypeM = 32'h0000_0010;
    mid();
    check_val("exc_flushD", 32'(hz_if.flushD), 32'd1);
    check_val("exc_flushW", 32'(hz_if.flushW), 32'd1);
    check_val("exc_redirect", 32'(hz_if.pc_redirectF), 32'd1);
    check_val("exc_stallE", 32'(hz_if.stallE), 32'd0);
    check_val("exc_no_done", 32'(hz_if.div_doneE), 32'd0);
    tick();
    clear_in();
    dn_cnt = 0; st_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      mid();
      if (hz_if.div_doneE) dn_cnt++;
      if (hz_if.stallF || hz_if.pc_redirectF) st_cnt++;
      tick();
    end
    check_val("exc_after_done", 32'(dn_cnt), 32'd0);
    check_val("exc_after_run", 32'(st_cnt), 32'd0);

`ifdef HAZARD_MEM_TIMEOUT_EN
    // Ack never arrives: error and flush in the 4th wait cycle.
    hz_if.mem_enM = 1'b1;
    st_cnt = 0; dn_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      mid();
      if (hz_if.stallM) st_cnt++;
      if (hz_if.mem_errM) dn_cnt++;
      tick();
    end
    check_val("tmo_stalls", 32'(st_cnt), 32'd3);
    check_val("tmo_early_err", 32'(dn_cnt), 32'd0);
    mid();
    check_val("tmo_err", 32'(hz_if.mem_errM), 32'd1);
    check_val("tmo_flushD", 32'(hz_if.flushD), 32'd1);
    check_val("tmo_redirect", 32'(hz_if.pc_redirectF), 32'd1);
    check_val("tmo_stallM", 32'(hz_if.stallM), 32'd0);
    tick();
    hz_if.mem_enM = 1'b0;
    mid();
    check_val("tmo_err_pulse", 32'(hz_if.mem_errM), 32'd0);
    tick();
`else
    // Without timeout the wait persists until an exception aborts it.
    hz_if.mem_enM = 1'b1;
    st_cnt = 0; dn_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      mid();
      if (hz_if.stallM) st_cnt++;
      if (hz_if.mem_errM) dn_cnt++;
      tick();
    end
    check_val("memwait_long", 32'(st_cnt), 32'd10);
    check_val("memwait_no_err", 32'(dn_cnt), 32'd0);
    hz_if.excepttypeM = 32'h1;
    mid();
    check_val("memexc_flushM", 32'(hz_if.flushM), 32'd1);
    check_val("memexc_stallM", 32'(hz_if.stallM), 32'd0);
    tick();
    clear_in();
    mid();
    check_val("memexc_run", 32'(hz_if.stallM), 32'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
